// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 shift-add multiplier sequencer driving a shared external ALU.
// alu_ctrl encoding: 2'd0 = ALU_ADD, 2'd1 = ALU_SUB.
// Optional macro ALU_MUL_SIGNED_EN adds the FIXA/FIXB two's-complement correction steps.
module alu_mul_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    input  logic        op_signed,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] product,
    output logic        busy,
    output logic [1:0]  alu_ctrl,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_cin,
    input  logic [7:0]  alu_out,
    input  logic        alu_cout
);
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;

`ifdef ALU_MUL_SIGNED_EN
    typedef enum logic [2:0] {IDLE, RUN, FIXA, FIXB, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, RUN, DONE} state_t;
`endif

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d, lo_q, lo_d, mcand_q, mcand_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] last_q, last_d;
`ifdef ALU_MUL_SIGNED_EN
    logic [7:0]  mplr_q, mplr_d;
    logic        sgn_q, sgn_d;
`else
    logic        unused_op_signed;
    assign unused_op_signed = op_signed;
`endif

    assign start_ready = state_q == IDLE;
    assign busy        = state_q != IDLE;
    assign res_valid   = state_q == DONE;
    assign product     = res_valid ? {hi_q, lo_q} : last_q;
    assign alu_cin     = 1'b0;

    // Next-state and ALU operand selection; one ALU operation per non-idle cycle.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
`ifdef ALU_MUL_SIGNED_EN
        mplr_d   = mplr_q;
        sgn_d    = sgn_q;
`endif
        alu_ctrl = ALU_ADD;
        alu_a    = 8'd0;
        alu_b    = 8'd0;
        case (state_q)
            IDLE: if (start_valid) begin
                mcand_d = op_a;
                lo_d    = op_b;
                hi_d    = 8'd0;
                cnt_d   = 3'd0;
`ifdef ALU_MUL_SIGNED_EN
                mplr_d  = op_b;
                sgn_d   = op_signed;
`endif
                state_d = RUN;
            end
            RUN: begin
                alu_a = hi_q;
                alu_b = lo_q[0] ? mcand_q : 8'd0;
                hi_d  = {alu_cout, alu_out[7:1]};
                lo_d  = {alu_out[0], lo_q[7:1]};
                cnt_d = cnt_q + 3'd1;
`ifdef ALU_MUL_SIGNED_EN
                if (cnt_q == 3'd7) state_d = sgn_q ? FIXA : DONE;
`else
                if (cnt_q == 3'd7) state_d = DONE;
`endif
            end
`ifdef ALU_MUL_SIGNED_EN
            FIXA: begin
                alu_ctrl = ALU_SUB;
                alu_a    = hi_q;
                alu_b    = mcand_q[7] ? mplr_q : 8'd0;
                hi_d     = alu_out;
                state_d  = FIXB;
            end
            FIXB: begin
                alu_ctrl = ALU_SUB;
                alu_a    = hi_q;
                alu_b    = mplr_q[7] ? mcand_q : 8'd0;
                hi_d     = alu_out;
                state_d  = DONE;
            end
`endif
            DONE: begin
                last_d = {hi_q, lo_q};
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any operation or pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hi_q    <= 8'd0;
            lo_q    <= 8'd0;
            mcand_q <= 8'd0;
            cnt_q   <= 3'd0;
            last_q  <= 16'd0;
`ifdef ALU_MUL_SIGNED_EN
            mplr_q  <= 8'd0;
            sgn_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
`ifdef ALU_MUL_SIGNED_EN
            mplr_q  <= mplr_d;
            sgn_q   <= sgn_d;
`endif
        end
    end
endmodule
